syst_drain: RTL

- Downstream stage of the systolic MAC column. It collects the per-lane partial-sum outputs (psumm_o/valid_o) of N nodes, which arrive skewed by one cycle per lane.
- Deskews them into one aligned result vector, then rounds and saturates each lane to OUT_WIDTH.
- Buffers results in a FIFO with a valid/ready output.
- Generates the array-wide enable so the array stalls instead of losing results under backpressure.

---
 rtl/syst_pkg.sv | 38 +++
 rtl/syst_fifo.sv | 68 ++++++
 rtl/syst_drain.sv | 122 ++++++++++++
 3 files changed

// File: rtl/syst_pkg.sv
// syst_pkg: shared helpers for the systolic drain stage.
//   lane_off   - bit offset of lane k in a packed vector of w-bit lanes
//   round_sat  - half-up rounding arithmetic right shift followed by
//                saturation to a signed out_w-bit range
package syst_pkg;

    // Width of the internal arithmetic; wide enough for SO_WIDTH+1 headroom.
    localparam int CALC_W = 64;

    function automatic int lane_off(input int k, input int w);
        return k * w;
    endfunction

    // x must already be sign-extended to CALC_W bits. The add cannot overflow
    // because the source width is well below CALC_W.
    function automatic logic signed [CALC_W-1:0] round_sat(
        input logic signed [CALC_W-1:0] x,
        input int                       out_w,
        input int                       shift
    );
        logic signed [CALC_W-1:0] t;
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        logic signed [CALC_W-1:0] r;
        t  = (x + (64'sd1 <<< (shift - 1))) >>> shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (t > hi) begin
            r = hi;
        end else if (t < lo) begin
            r = lo;
        end else begin
            r = t;
        end
        return r;
    endfunction

endpackage

// File: rtl/syst_fifo.sv
// syst_fifo: synchronous first-word-fall-through FIFO.
//   clk, rstn         - clock, asynchronous active-low reset (pointers/count)
//   wr_en, wr_data    - write request; ignored when full
//   rd_en, rd_data    - read request; ignored when empty; rd_data is the head
//   empty, full, count- occupancy status, all derived from registers
module syst_fifo
    import syst_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             wr_ok_s;
    logic             rd_ok_s;

    assign wr_ok_s = wr_en & ~full;
    assign rd_ok_s = rd_en & ~empty;
    assign empty   = (count_r == CW'(0));
    assign full    = (count_r == CW'(DEPTH));
    assign count   = count_r;
    assign rd_data = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            if (wr_ok_s && !rd_ok_s) begin
                count_r <= count_r + CW'(1);
            end else if (rd_ok_s && !wr_ok_s) begin
                count_r <= count_r - CW'(1);
            end
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

endmodule

// File: rtl/syst_drain.sv
// syst_drain: drain stage of a systolic MAC column.
//   clk, rstn  - clock, asynchronous active-low reset
//   psumm_i    - N signed partial sums, lane k at [k*SO_WIDTH +: SO_WIDTH]
//   valid_i    - per-lane valid; lane k trails lane 0 by k cycles
//   enable_o   - array-wide enable; low while the result FIFO is full
//   out_data   - rounded/saturated aligned lanes (FIFO head)
//   out_valid  - FIFO not empty
//   out_ready  - consumer handshake
//   err_o      - sticky lane-misalignment flag
module syst_drain
    import syst_pkg::*;
#(
    parameter int N         = 4,
    parameter int SO_WIDTH  = 32,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 4,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [N*SO_WIDTH-1:0]  psumm_i,
    input  logic [N-1:0]           valid_i,
    output logic                   enable_o,
    output logic [N*OUT_WIDTH-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   err_o
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [SO_WIDTH-1:0]    al_data_s [N];
    logic [N-1:0]           al_valid_s;
    logic [N*OUT_WIDTH-1:0] wr_data_s;
    logic [CW-1:0]          count_s;
    logic                   full_s;
    logic                   empty_s;
    logic                   enable_s;
    logic                   all_valid_s;
    logic                   wr_en_s;
    logic                   mis_s;
    logic                   err_r;

    // Only the registered count drives the enable, so out_ready never
    // reaches the array enable combinationally.
    assign enable_s    = (count_s != CW'(DEPTH));
    assign all_valid_s = &al_valid_s;
    assign wr_en_s     = enable_s & ~full_s & all_valid_s;
    assign mis_s       = enable_s & (|al_valid_s) & ~all_valid_s;

    genvar k;
    generate
        for (k = 0; k < N; k++) begin : g_lane
            localparam int STG = N - 1 - k;
            if (STG == 0) begin : g_pass
                // Last lane arrives already aligned.
                assign al_data_s[k]  = psumm_i[lane_off(k, SO_WIDTH) +: SO_WIDTH];
                assign al_valid_s[k] = valid_i[k];
            end else begin : g_dly
                logic [SO_WIDTH-1:0] d_r [STG];
                logic [STG-1:0]      v_r;

                // Valid shift chain; frozen together with the array when disabled.
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        v_r <= '0;
                    end else if (enable_s) begin
                        v_r[0] <= valid_i[k];
                        for (int s = 1; s < STG; s++) begin
                            v_r[s] <= v_r[s-1];
                        end
                    end
                end

                // Data shift chain, unreset, qualified by the valid chain.
                always_ff @(posedge clk) begin
                    if (enable_s) begin
                        d_r[0] <= psumm_i[lane_off(k, SO_WIDTH) +: SO_WIDTH];
                        for (int s = 1; s < STG; s++) begin
                            d_r[s] <= d_r[s-1];
                        end
                    end
                end

                assign al_data_s[k]  = d_r[STG-1];
                assign al_valid_s[k] = v_r[STG-1];
            end

            assign wr_data_s[lane_off(k, OUT_WIDTH) +: OUT_WIDTH] =
                OUT_WIDTH'(round_sat(CALC_W'(signed'(al_data_s[k])), OUT_WIDTH, SHIFT));
        end
    endgenerate

    // Sticky misalignment flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_r <= 1'b0;
        end else if (mis_s) begin
            err_r <= 1'b1;
        end
    end

    syst_fifo #(
        .WIDTH(N * OUT_WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rstn   (rstn),
        .wr_en  (wr_en_s),
        .wr_data(wr_data_s),
        .rd_en  (out_ready),
        .rd_data(out_data),
        .empty  (empty_s),
        .full   (full_s),
        .count  (count_s)
    );

    assign enable_o  = enable_s;
    assign out_valid = ~empty_s;
    assign err_o     = err_r;

endmodule
